// File: rtl/mvm_pkg.sv
// mvm_pkg: definitions shared across the matrix-vector multiply engine.
//   state_t        sequencer FSM states (IDLE, RUN)
//   DEF_VEC_ADDRW  default vector RAM address width
//   DEF_MAT_ADDRW  default matrix RAM address width
package mvm_pkg;

  localparam int DEF_VEC_ADDRW = 8;
  localparam int DEF_MAT_ADDRW = 9;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/ctrl_cnt.sv
// ctrl_cnt: clearable up-counter with terminal-count look-ahead flags.
//   clk      in   rising-edge clock
//   rst      in   synchronous active-low reset (count -> 0)
//   clr      in   synchronous clear to 0 (priority over inc)
//   inc      in   advance count by one
//   term     in   W  terminal value (last index of the sweep dimension)
//   tc       out  count currently equals term
//   tc_next  out  count+1 equals term (next increment lands on terminal)
module ctrl_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic         tc,
  output logic         tc_next
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + W'(1);
    end
  end

  assign tc      = (cnt == term);
  assign tc_next = ((cnt + W'(1)) == term);

endmodule

// File: rtl/ctrl.sv
// ctrl: read-address sequencer for the matrix-vector multiply engine.
// One start pulse launches a row-major sweep: for every matrix row each vector
// word is addressed once, one beat per cycle, with accumulator framing.
//   clk                     in   rising-edge clock
//   rst                     in   synchronous active-low reset
//   start                   in   one-cycle launch pulse
//   vec_start_addr          in   first vector word address
//   vec_num_words           in   words per row (N)
//   mat_start_addr          in   first matrix word address
//   mat_num_rows_per_olane  in   rows per output lane (R)
//   vec_raddr               out  vector RAM read address
//   mat_raddr               out  matrix RAM read address
//   accum_first             out  beat is word 0 of a row
//   accum_last              out  beat is word N-1 of a row
//   ovalid                  out  address/framing beat valid
//   busy                    out  sweep in progress
module ctrl
  import mvm_pkg::*;
#(
  parameter int VEC_ADDRW = DEF_VEC_ADDRW,
  parameter int MAT_ADDRW = DEF_MAT_ADDRW,
  parameter int VEC_SIZEW = VEC_ADDRW + 1,
  parameter int MAT_SIZEW = MAT_ADDRW + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [VEC_ADDRW-1:0] vec_start_addr,
  input  logic [VEC_SIZEW-1:0] vec_num_words,
  input  logic [MAT_ADDRW-1:0] mat_start_addr,
  input  logic [MAT_SIZEW-1:0] mat_num_rows_per_olane,
  output logic [VEC_ADDRW-1:0] vec_raddr,
  output logic [MAT_ADDRW-1:0] mat_raddr,
  output logic                 accum_first,
  output logic                 accum_last,
  output logic                 ovalid,
  output logic                 busy
);

  state_t               state;
  logic [VEC_ADDRW-1:0] vec_base;
  logic [VEC_SIZEW-1:0] word_last;
  logic [MAT_SIZEW-1:0] row_last;
  logic                 final_beat;   // current beat is row R-1, word N-1

  logic launch;
  logic running;
  logic word_tc, word_tc_next;
  logic row_tc, row_tc_next;
  logic nxt_word_last, nxt_row_last;

  assign launch  = (state == IDLE) && start &&
                   (vec_num_words != '0) && (mat_num_rows_per_olane != '0);
  assign running = (state == RUN);

  ctrl_cnt #(.W(VEC_SIZEW)) u_word_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (launch || (running && word_tc)),
    .inc     (running && !word_tc),
    .term    (word_last),
    .tc      (word_tc),
    .tc_next (word_tc_next)
  );

  ctrl_cnt #(.W(MAT_SIZEW)) u_row_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (launch || (running && final_beat)),
    .inc     (running && word_tc && !final_beat),
    .term    (row_last),
    .tc      (row_tc),
    .tc_next (row_tc_next)
  );

  // Framing for the following beat is decided one cycle ahead so that every
  // output stays a plain register: a row wrap resets the word index to 0 and
  // moves the row index on by one.
  assign nxt_word_last = word_tc ? (word_last == '0) : word_tc_next;
  assign nxt_row_last  = word_tc ? row_tc_next : row_tc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      vec_base    <= '0;
      word_last   <= '0;
      row_last    <= '0;
      final_beat  <= 1'b0;
      vec_raddr   <= '0;
      mat_raddr   <= '0;
      accum_first <= 1'b0;
      accum_last  <= 1'b0;
      ovalid      <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          accum_first <= 1'b0;
          accum_last  <= 1'b0;
          ovalid      <= 1'b0;
          busy        <= 1'b0;
          if (launch) begin
            state       <= RUN;
            vec_base    <= vec_start_addr;
            word_last   <= vec_num_words - VEC_SIZEW'(1);
            row_last    <= mat_num_rows_per_olane - MAT_SIZEW'(1);
            vec_raddr   <= vec_start_addr;
            mat_raddr   <= mat_start_addr;
            accum_first <= 1'b1;
            accum_last  <= (vec_num_words == VEC_SIZEW'(1));
            final_beat  <= (vec_num_words == VEC_SIZEW'(1)) &&
                           (mat_num_rows_per_olane == MAT_SIZEW'(1));
            ovalid      <= 1'b1;
            busy        <= 1'b1;
          end
        end
        RUN: begin
          if (final_beat) begin
            // Addresses hold their last value; only framing drops.
            state       <= IDLE;
            final_beat  <= 1'b0;
            accum_first <= 1'b0;
            accum_last  <= 1'b0;
            ovalid      <= 1'b0;
            busy        <= 1'b0;
          end else begin
            mat_raddr   <= mat_raddr + MAT_ADDRW'(1);
            vec_raddr   <= word_tc ? vec_base : (vec_raddr + VEC_ADDRW'(1));
            accum_first <= word_tc;
            accum_last  <= nxt_word_last;
            final_beat  <= nxt_word_last && nxt_row_last;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl.sv
module tb_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] vec_start_addr;
  logic [8:0] vec_num_words;
  logic [8:0] mat_start_addr;
  logic [9:0] mat_num_rows_per_olane;
  logic [7:0] vec_raddr;
  logic [8:0] mat_raddr;
  logic       accum_first, accum_last, ovalid, busy;

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  ctrl #(.VEC_ADDRW(8), .MAT_ADDRW(9)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .start                  (start),
    .vec_start_addr         (vec_start_addr),
    .vec_num_words          (vec_num_words),
    .mat_start_addr         (mat_start_addr),
    .mat_num_rows_per_olane (mat_num_rows_per_olane),
    .vec_raddr              (vec_raddr),
    .mat_raddr              (mat_raddr),
    .accum_first            (accum_first),
    .accum_last             (accum_last),
    .ovalid                 (ovalid),
    .busy                   (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_cfg();
    vec_start_addr         = 8'($urandom);
    vec_num_words          = 9'($urandom_range(0, 15));
    mat_start_addr         = 9'($urandom);
    mat_num_rows_per_olane = 10'($urandom_range(0, 7));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"},   32'(busy),        32'd0);
    chk({tag, ".ovalid"}, 32'(ovalid),      32'd0);
    chk({tag, ".first"},  32'(accum_first), 32'd0);
    chk({tag, ".last"},   32'(accum_last),  32'd0);
  endtask

  // Reference: beat k of an R x N sweep, from the row-major formula.
  // Called at a point just after a clock edge with the DUT idle.
  task automatic run_sweep(input int unsigned vs, input int unsigned n,
                           input int unsigned ms, input int unsigned r,
                           input int pulse_at, input int unsigned exp_beats,
                           input int unsigned exp_lvec, input int unsigned exp_lmat);
    int unsigned beats = 0;
    vec_start_addr         = 8'(vs);
    vec_num_words          = 9'(n);
    mat_start_addr         = 9'(ms);
    mat_num_rows_per_olane = 10'(r);
    start = 1'b1;
    step();
    start = 1'b0;
    scramble_cfg();
    for (int k = 0; k < int'(r * n); k++) begin
      int unsigned word = 32'(k) % n;
      string t = $sformatf("beat%0d(vs%0d n%0d ms%0d r%0d)", k, vs, n, ms, r);
      chk({t, ".vec"},    32'(vec_raddr),   (vs + word) % 256);
      chk({t, ".mat"},    32'(mat_raddr),   (ms + 32'(k)) % 512);
      chk({t, ".first"},  32'(accum_first), 32'(word == 0));
      chk({t, ".last"},   32'(accum_last),  32'(word == n - 1));
      chk({t, ".ovalid"}, 32'(ovalid),      32'd1);
      chk({t, ".busy"},   32'(busy),        32'd1);
      if (ovalid === 1'b1) beats++;
      if (k == pulse_at) begin
        start = 1'b1;
        scramble_cfg();
        step();
        start = 1'b0;
      end else begin
        step();
      end
    end
    chk("beat_count", beats, exp_beats);
    chk_idle("after_sweep");
    chk("after_sweep.vec_hold", 32'(vec_raddr), exp_lvec);
    chk("after_sweep.mat_hold", 32'(mat_raddr), exp_lmat);
  endtask

  typedef struct {
    int unsigned vs, n, ms, r;
    int          pulse_at;
    int unsigned exp_beats, exp_lvec, exp_lmat;
  } vec_t;

  vec_t tbl[5];

  initial begin
    tbl[0] = '{vs: 3,   n: 4, ms: 5,   r: 2, pulse_at: -1, exp_beats: 8, exp_lvec: 6,  exp_lmat: 12};
    tbl[1] = '{vs: 7,   n: 1, ms: 1,   r: 3, pulse_at: -1, exp_beats: 3, exp_lvec: 7,  exp_lmat: 3};
    tbl[2] = '{vs: 0,   n: 2, ms: 510, r: 2, pulse_at: -1, exp_beats: 4, exp_lvec: 1,  exp_lmat: 1};
    tbl[3] = '{vs: 254, n: 3, ms: 100, r: 2, pulse_at: 2,  exp_beats: 6, exp_lvec: 0,  exp_lmat: 105};
    tbl[4] = '{vs: 10,  n: 5, ms: 20,  r: 1, pulse_at: 1,  exp_beats: 5, exp_lvec: 14, exp_lmat: 24};

    rst = 1'b0;
    start = 1'b0;
    scramble_cfg();

    // Long reset, with start toggling to show it is ignored while in reset.
    for (int i = 0; i < 25; i++) begin
      start = i[0];
      step();
    end
    start = 1'b0;
    chk_idle("reset");
    chk("reset.vec", 32'(vec_raddr), 32'd0);
    chk("reset.mat", 32'(mat_raddr), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk_idle("post_reset_no_start");

    // Directed table.
    foreach (tbl[i])
      run_sweep(tbl[i].vs, tbl[i].n, tbl[i].ms, tbl[i].r, tbl[i].pulse_at,
                tbl[i].exp_beats, tbl[i].exp_lvec, tbl[i].exp_lmat);

    // Zero-size launches are no-ops.
    for (int z = 0; z < 2; z++) begin
      vec_start_addr         = 8'd9;
      vec_num_words          = (z == 0) ? 9'd0 : 9'd3;
      mat_start_addr         = 9'd9;
      mat_num_rows_per_olane = (z == 0) ? 10'd4 : 10'd0;
      start = 1'b1;
      step();
      start = 1'b0;
      chk_idle($sformatf("zero_launch%0d", z));
      step();
      chk_idle($sformatf("zero_launch%0d.later", z));
    end

    // Back-to-back random configs, each launched in the first idle cycle.
    for (int i = 0; i < 10; i++) begin
      int unsigned vs = $urandom_range(1, 9), n = $urandom_range(1, 9);
      int unsigned ms = $urandom_range(1, 9), r = $urandom_range(1, 9);
      run_sweep(vs, n, ms, r, -1, r * n, (vs + n - 1) % 256, (ms + r * n - 1) % 512);
    end

    // Wider random configs with wrap and occasional mid-sweep start pulses.
    for (int i = 0; i < 15; i++) begin
      int unsigned vs = $urandom_range(0, 255), n = $urandom_range(1, 12);
      int unsigned ms = $urandom_range(0, 511), r = $urandom_range(1, 6);
      int pa = int'($urandom_range(0, r * n)) - 1;
      run_sweep(vs, n, ms, r, pa, r * n, (vs + n - 1) % 256, (ms + r * n - 1) % 512);
    end

    // Reset in the middle of a sweep aborts it at the next edge.
    vec_start_addr         = 8'd4;
    vec_num_words          = 9'd2;
    mat_start_addr         = 9'd510;
    mat_num_rows_per_olane = 10'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("abort.beat0.mat", 32'(mat_raddr), 32'd510);
    step();
    chk("abort.beat1.mat", 32'(mat_raddr), 32'd511);
    step();
    chk("abort.beat2.mat", 32'(mat_raddr), 32'd0);
    rst = 1'b0;
    step();
    chk_idle("abort");
    chk("abort.vec", 32'(vec_raddr), 32'd0);
    chk("abort.mat", 32'(mat_raddr), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk_idle("abort.after_release");

    // Sequencer still launches cleanly after the abort.
    run_sweep(2, 3, 7, 2, -1, 6, 4, 12);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
